fp_norm_round: RTL and testbench

Post-add normalize-and-round stage of the FPU. It accepts the raw, unnormalized sign/exponent/mantissa produced by the single-precision adder's align-and-add stages. It then performs carry handling, leading-zero normalization, round-to-nearest-even and IEEE-754 packing over a fixed 3-stage pipeline, and presents the packed result with status flags to the FPU writeback.

---
 rtl/fp_norm_round.sv | 172 +++++++++++++++++
 tb/tb_fp_norm_round.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fp_norm_round.sv
// Post-add normalize/round stage: carry handling + LZC, normalize, RNE round and
// binary32 packing over a 3-register pipeline with per-stage valid bits.
module fp_norm_round #(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic                 sign_in,
  input  logic [7:0]           exp_in,
  input  logic [27:0]          mant_in,
  input  logic                 nan_in,
  input  logic                 inf_in,
  output logic [DATAWIDTH-1:0] s,
  output logic                 s_ena,
  output logic                 nan,
  output logic                 over,
  output logic                 under,
  output logic                 done
);

  localparam int unsigned EW  = 10;
  localparam int unsigned NMW = 27;
  localparam int unsigned LZW = 5;
  localparam int unsigned FW  = 23;

  // Leading zeros of a 27-bit value; 27 when all bits are clear.
  function automatic logic [LZW-1:0] lzc27(input logic [NMW-1:0] m);
    lzc27 = LZW'(27);
    for (int i = 0; i < int'(NMW); i++) begin
      if (m[i]) lzc27 = LZW'(26 - i);
    end
  endfunction

  // Stage 1: fold the carry back into the 27-bit frame, otherwise count zeros.
  logic [NMW-1:0] mant1_c;
  logic [EW-1:0]  exp1_c;
  logic [LZW-1:0] lzc1_c;

  always_comb begin
    mant1_c = mant_in[26:0];
    exp1_c  = EW'(exp_in);
    lzc1_c  = '0;
    if (mant_in[27]) begin
      mant1_c = {mant_in[27:2], mant_in[1] | mant_in[0]};
      exp1_c  = EW'(exp_in) + EW'(1);
    end else begin
      lzc1_c  = lzc27(mant_in[26:0]);
    end
  end

  logic           v1, sign1, nan1, inf1, zero1;
  logic [NMW-1:0] mant1;
  logic [EW-1:0]  exp1;
  logic [LZW-1:0] lzc1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      sign1 <= 1'b0;
      nan1  <= 1'b0;
      inf1  <= 1'b0;
      zero1 <= 1'b0;
      mant1 <= '0;
      exp1  <= '0;
      lzc1  <= '0;
    end else begin
      v1    <= ena;
      sign1 <= sign_in;
      nan1  <= nan_in;
      inf1  <= inf_in;
      zero1 <= (mant_in == 28'd0);
      mant1 <= mant1_c;
      exp1  <= exp1_c;
      lzc1  <= lzc1_c;
    end
  end

  // Stage 2: normalize; a non-positive adjusted exponent flushes to zero.
  logic [EW-1:0]  exp2_c;
  logic [NMW-1:0] mant2_c;
  logic           under2_c;

  always_comb begin
    exp2_c   = exp1 - EW'(lzc1);
    mant2_c  = mant1 << lzc1;
    under2_c = exp2_c[EW-1] || (exp2_c == '0);
  end

  logic           v2, sign2, nan2, inf2, zero2, under2;
  logic [NMW-1:0] mant2;
  logic [EW-1:0]  exp2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2     <= 1'b0;
      sign2  <= 1'b0;
      nan2   <= 1'b0;
      inf2   <= 1'b0;
      zero2  <= 1'b0;
      under2 <= 1'b0;
      mant2  <= '0;
      exp2   <= '0;
    end else begin
      v2     <= v1;
      sign2  <= sign1;
      nan2   <= nan1;
      inf2   <= inf1;
      zero2  <= zero1;
      under2 <= under2_c;
      mant2  <= mant2_c;
      exp2   <= exp2_c;
    end
  end

  // Stage 3: round to nearest even on {hidden, fraction}, then pack by priority.
  logic          inc_c;
  logic [24:0]   rnd_c;
  logic [FW-1:0] frac_c;
  logic [EW-1:0] exp3_c;
  logic          ovf_c;
  logic [31:0]   s_c;
  logic          nan_c, over_c, under_c;

  always_comb begin
    inc_c   = mant2[2] & (mant2[1] | mant2[0] | mant2[3]);
    rnd_c   = {1'b0, mant2[26:3]} + 25'(inc_c);
    frac_c  = rnd_c[24] ? '0 : rnd_c[FW-1:0];
    exp3_c  = exp2 + EW'(rnd_c[24]);
    ovf_c   = !exp3_c[EW-1] && (exp3_c >= EW'(255));
    s_c     = {sign2, exp3_c[7:0], frac_c};
    nan_c   = 1'b0;
    over_c  = 1'b0;
    under_c = 1'b0;
    if (nan2) begin
      s_c   = 32'h7FC0_0000;
      nan_c = 1'b1;
    end else if (inf2) begin
      s_c    = {sign2, 8'hFF, 23'h0};
      over_c = 1'b1;
    end else if (zero2) begin
      s_c = {sign2, 31'h0};
    end else if (under2) begin
      s_c     = {sign2, 31'h0};
      under_c = 1'b1;
    end else if (ovf_c) begin
      s_c    = {sign2, 8'hFF, 23'h0};
      over_c = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ena <= 1'b0;
      s     <= '0;
      nan   <= 1'b0;
      over  <= 1'b0;
      under <= 1'b0;
    end else begin
      s_ena <= v2;
      if (v2) begin
        s     <= DATAWIDTH'(s_c);
        nan   <= nan_c;
        over  <= over_c;
        under <= under_c;
      end
    end
  end

  assign done = !(v1 || v2 || s_ena);

endmodule

// File: tb/tb_fp_norm_round.sv
// Directed bench for fp_norm_round: expected results are queued at issue time
// and popped when s_ena appears, checking value, flags and 3-cycle latency.
module tb_fp_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic [27:0] mant_in;
  logic        nan_in;
  logic        inf_in;
  logic [31:0] s;
  logic        s_ena, nan, over, under, done;

  fp_norm_round #(.DATAWIDTH(32)) dut (
    .clk(clk), .rst(rst), .ena(ena), .sign_in(sign_in), .exp_in(exp_in),
    .mant_in(mant_in), .nan_in(nan_in), .inf_in(inf_in), .s(s), .s_ena(s_ena),
    .nan(nan), .over(over), .under(under), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s;
    logic [2:0]  flags;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  logic [31:0] hold_s   = '0;

  localparam logic [2:0] F_NONE  = 3'b000;
  localparam logic [2:0] F_NAN   = 3'b100;
  localparam logic [2:0] F_OVER  = 3'b010;
  localparam logic [2:0] F_UNDER = 3'b001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance one cycle and score whatever the DUT presents.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (s_ena) begin
      if (sb.size() == 0) begin
        chk("unexpected_s_ena", 32'(s_ena), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result_s", s, e.s);
        chk("result_flags", 32'({nan, over, under}), 32'(e.flags));
        chk("latency", 32'(cyc - e.cyc), 32'd3);
        hold_s = e.s;
      end
    end else begin
      chk("hold_s", s, hold_s);
    end
  endtask

  task automatic drive(input logic sg, input logic [7:0] e, input logic [27:0] m,
                       input logic n, input logic i, input logic [31:0] es,
                       input logic [2:0] ef);
    exp_t x;
    ena = 1'b1; sign_in = sg; exp_in = e; mant_in = m; nan_in = n; inf_in = i;
    x.s = es; x.flags = ef; x.cyc = cyc;
    sb.push_back(x);
    tick();
  endtask

  task automatic idle(input int n);
    ena = 1'b0; nan_in = 1'b0; inf_in = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; sign_in = 1'b0; exp_in = '0; mant_in = '0;
    nan_in = 1'b0; inf_in = 1'b0;
    #12;
    chk("reset_s_ena", 32'(s_ena), 32'd0);
    chk("reset_s", s, 32'd0);
    chk("reset_flags", 32'({nan, over, under}), 32'd0);
    chk("reset_done", 32'(done), 32'd1);
    #5 rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back stream of directed cases
    drive(1'b0, 8'd127, 28'h8000000, 1'b0, 1'b0, 32'h40000000, F_NONE);
    chk("done_busy", 32'(done), 32'd0);
    drive(1'b0, 8'd127, 28'h0000008, 1'b0, 1'b0, 32'h34000000, F_NONE);
    drive(1'b0, 8'd127, 28'h4000004, 1'b0, 1'b0, 32'h3F800000, F_NONE);
    drive(1'b0, 8'd127, 28'h400000C, 1'b0, 1'b0, 32'h3F800002, F_NONE);
    drive(1'b0, 8'd127, 28'h7FFFFFC, 1'b0, 1'b0, 32'h40000000, F_NONE);
    drive(1'b0, 8'd254, 28'h8000000, 1'b0, 1'b0, 32'h7F800000, F_OVER);
    drive(1'b1, 8'd10,  28'h4000000, 1'b1, 1'b1, 32'h7FC00000, F_NAN);
    drive(1'b1, 8'd3,   28'h0100000, 1'b0, 1'b0, 32'h80000000, F_UNDER);
    drive(1'b1, 8'd10,  28'h4000000, 1'b0, 1'b1, 32'hFF800000, F_OVER);
    drive(1'b1, 8'd100, 28'h0000000, 1'b0, 1'b0, 32'h80000000, F_NONE);
    drive(1'b0, 8'd1,   28'h4000000, 1'b0, 1'b0, 32'h00800000, F_NONE);
    drive(1'b0, 8'd1,   28'h2000000, 1'b0, 1'b0, 32'h00000000, F_UNDER);
    drive(1'b0, 8'd254, 28'h7FFFFFC, 1'b0, 1'b0, 32'h7F800000, F_OVER);
    drive(1'b0, 8'd127, 28'h800000C, 1'b0, 1'b0, 32'h40000001, F_NONE);
    drive(1'b0, 8'd127, 28'h8000009, 1'b0, 1'b0, 32'h40000001, F_NONE);
    idle(6);
    chk("drain_empty", 32'(sb.size()), 32'd0);
    chk("done_idle", 32'(done), 32'd1);

    // Four back-to-back operations with reset between the 2nd and 3rd edges
    drive(1'b0, 8'd127, 28'h8000000, 1'b0, 1'b0, 32'h40000000, F_NONE);
    drive(1'b0, 8'd127, 28'h4000004, 1'b0, 1'b0, 32'h3F800000, F_NONE);
    ena = 1'b1; mant_in = 28'h400000C;
    #2 rst = 1'b1;
    #1;
    chk("midrst_s_ena", 32'(s_ena), 32'd0);
    chk("midrst_s", s, 32'd0);
    chk("midrst_flags", 32'({nan, over, under}), 32'd0);
    chk("midrst_done", 32'(done), 32'd1);
    sb.delete();
    hold_s = '0;
    idle(3);
    #3 rst = 1'b0;
    idle(2);
    chk("postrst_done", 32'(done), 32'd1);
    drive(1'b1, 8'd127, 28'h400000C, 1'b0, 1'b0, 32'hBF800002, F_NONE);
    idle(5);
    chk("final_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
